// File: rtl/psmac_accumulator_pkg.sv
// Shared types and widths for the precision-scalable MAC accumulation stage.
package psmac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

  localparam int PSMAC_Y_W       = 16;
  localparam int PSMAC_LANE_IN_W = 8;

endpackage

// File: rtl/psmac_accumulator_if.sv
// Control, input-beat and result ports of the accumulator, bundled for the MAC side (master) and the accumulator (slave).
interface psmac_accumulator_if #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
);

  logic                           start;
  logic [LEN_W-1:0]               cfg_len;
  logic                           cfg_split;
  logic                           in_valid;
  logic [psmac_pkg::PSMAC_Y_W-1:0] in_y;
  logic                           in_ready;
  logic                           out_valid;
  logic                           out_ready;
  logic [ACC_W-1:0]               out_data;
  logic [1:0]                     out_sat;
  logic                           err_drop;
  logic                           busy;

  modport master (
    output start, cfg_len, cfg_split, in_valid, in_y, out_ready,
    input  in_ready, out_valid, out_data, out_sat, err_drop, busy
  );

  modport slave (
    input  start, cfg_len, cfg_split, in_valid, in_y, out_ready,
    output in_ready, out_valid, out_data, out_sat, err_drop, busy
  );

endinterface

// File: rtl/psmac_accumulator_sat_add.sv
// Signed two's-complement adder that clamps to the W-bit range and flags when it did.
module sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;

  assign raw = a + b;
  // Overflow only when both operands share a sign and the result does not.
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

  always_comb begin
    sum = raw;
    if (ovf) begin
      sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/psmac_accumulator.sv
// Accumulates a programmed number of MAC results, either as one wide sum or as two packed byte lanes.
//   state | meaning
//   IDLE  | waiting for start; result of the previous run held
//   ACC   | accepting beats until the programmed count is reached
//   DONE  | result valid, waiting for the consumer
module psmac_accumulator
  import psmac_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input logic                clk,
  input logic                rst,
  psmac_accumulator_if.slave bus
);

  localparam int LANE_W = ACC_W / 2;

  acc_state_t        state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              split_q;
  logic [ACC_W-1:0]  acc_q;
  logic [LANE_W-1:0] hi_q;
  logic [LANE_W-1:0] lo_q;
  logic [1:0]        sat_q;
  logic              drop_q;

  logic [PSMAC_LANE_IN_W-1:0] byte_hi;
  logic [PSMAC_LANE_IN_W-1:0] byte_lo;
  logic [ACC_W-1:0]  wide_in;
  logic [LANE_W-1:0] hi_in;
  logic [LANE_W-1:0] lo_in;
  logic [ACC_W-1:0]  acc_sum;
  logic [LANE_W-1:0] hi_sum;
  logic [LANE_W-1:0] lo_sum;
  logic              acc_ovf;
  logic              hi_ovf;
  logic              lo_ovf;
  logic              last_beat;

  assign byte_hi = bus.in_y[PSMAC_Y_W-1 -: PSMAC_LANE_IN_W];
  assign byte_lo = bus.in_y[PSMAC_LANE_IN_W-1:0];
  assign wide_in = {{(ACC_W-PSMAC_Y_W){bus.in_y[PSMAC_Y_W-1]}}, bus.in_y};
  assign hi_in   = {{(LANE_W-PSMAC_LANE_IN_W){byte_hi[PSMAC_LANE_IN_W-1]}}, byte_hi};
  assign lo_in   = {{(LANE_W-PSMAC_LANE_IN_W){byte_lo[PSMAC_LANE_IN_W-1]}}, byte_lo};

  sat_add #(.W(ACC_W))  u_sat_full (.a(acc_q), .b(wide_in), .sum(acc_sum), .ovf(acc_ovf));
  sat_add #(.W(LANE_W)) u_sat_hi   (.a(hi_q),  .b(hi_in),   .sum(hi_sum),  .ovf(hi_ovf));
  sat_add #(.W(LANE_W)) u_sat_lo   (.a(lo_q),  .b(lo_in),   .sum(lo_sum),  .ovf(lo_ovf));

  assign last_beat = (cnt_q == (len_q - LEN_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= LEN_W'(1);
      cnt_q   <= '0;
      split_q <= 1'b0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sat_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            len_q   <= (bus.cfg_len == '0) ? LEN_W'(1) : bus.cfg_len;
            split_q <= bus.cfg_split;
            cnt_q   <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sat_q   <= '0;
            // A beat arriving with start is still a drop, so it seeds the fresh flag.
            drop_q  <= bus.in_valid;
            state_q <= ACC;
          end else if (bus.in_valid) begin
            drop_q <= 1'b1;
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            if (split_q) begin
              hi_q  <= hi_sum;
              lo_q  <= lo_sum;
              sat_q <= sat_q | {hi_ovf, lo_ovf};
            end else begin
              acc_q    <= acc_sum;
              sat_q[0] <= sat_q[0] | acc_ovf;
            end
            cnt_q <= cnt_q + LEN_W'(1);
            if (last_beat) state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.in_valid)  drop_q  <= 1'b1;
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ACC) || (state_q == DONE);
  assign bus.out_data  = split_q ? {hi_q, lo_q} : acc_q;
  assign bus.out_sat   = sat_q;
  assign bus.err_drop  = drop_q;

endmodule

// File: tb/tb_psmac_accumulator.sv
// Directed scoreboard bench: stimulus pushes expected results, a monitor checks each output handshake.
module tb_psmac_accumulator;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sat;
    logic        drop;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  psmac_accumulator_if #(.ACC_W(32), .LEN_W(16)) bus ();

  psmac_accumulator #(.ACC_W(32), .LEN_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] s, input logic dr);
    exp_t e;
    e.data = d;
    e.sat  = s;
    e.drop = dr;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [15:0] len, input logic split);
    bus.start     = 1'b1;
    bus.cfg_len   = len;
    bus.cfg_split = split;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic beat(input logic [15:0] y);
    bus.in_valid = 1'b1;
    bus.in_y     = y;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("done_timeout", {31'd0, bus.out_valid}, 32'd1);
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", bus.out_data, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk("res_data", bus.out_data, e.data);
          chk("res_sat", {30'd0, bus.out_sat}, {30'd0, e.sat});
          chk("res_drop", {31'd0, bus.err_drop}, {31'd0, e.drop});
        end
      end
    end
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.cfg_len   = '0;
    bus.cfg_split = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_y      = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_sat", {30'd0, bus.out_sat}, 32'd0);
    chk("rst_err_drop", {31'd0, bus.err_drop}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic non-split: 100 - 50 + 7 - 1 = 56.
    push(32'd56, 2'b00, 1'b0);
    do_start(16'd4, 1'b0);
    chk("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
    beat(16'd100);
    beat(-16'sd50);
    beat(16'd7);
    chk("t1_not_early", {31'd0, bus.out_valid}, 32'd0);
    beat(-16'sd1);
    chk("t1_latency", {31'd0, bus.out_valid}, 32'd1);
    tick();
    chk("t1_idle_after", {31'd0, bus.busy}, 32'd0);
    chk("t1_hold", bus.out_data, 32'd56);

    // Split lanes: hi 5 + (-2) = 3, lo -3 + 3 = 0.
    push(32'h0003_0000, 2'b00, 1'b0);
    do_start(16'd2, 1'b1);
    beat(16'h05FD);
    beat(16'hFE03);
    wait_done();
    tick();

    // Saturation: 300 * 127 exceeds 32767 in both lanes.
    push(32'h7FFF_7FFF, 2'b11, 1'b0);
    do_start(16'd300, 1'b1);
    for (int i = 0; i < 300; i++) beat(16'h7F7F);
    wait_done();
    tick();
    chk("t3_sat_sticky", {30'd0, bus.out_sat}, 32'd3);

    // Backpressure, drop during DONE, and start ignored while busy.
    bus.out_ready = 1'b0;
    push(32'd1234, 2'b00, 1'b1);
    do_start(16'd2, 1'b0);
    chk("t4_sat_cleared", {30'd0, bus.out_sat}, 32'd0);
    beat(16'd1000);
    beat(16'd234);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_data", bus.out_data, 32'd1234);
      chk("t4_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      if (i == 1) begin
        bus.in_valid = 1'b1;
        bus.in_y     = 16'd5;
      end
      if (i == 3) bus.start = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
    end
    chk("t4_err_drop", {31'd0, bus.err_drop}, 32'd1);
    chk("t4_sum_unchanged", bus.out_data, 32'd1234);
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t4_start_ignored", {31'd0, bus.busy}, 32'd0);

    // cfg_len = 0 acts as a single beat.
    push(32'hFFFF_8000, 2'b00, 1'b0);
    do_start(16'd0, 1'b0);
    chk("t5_drop_cleared", {31'd0, bus.err_drop}, 32'd0);
    beat(16'h8000);
    chk("t5_len0_done", {31'd0, bus.out_valid}, 32'd1);
    tick();

    // Gaps between beats do not advance the count: 10 + 20 - 5 = 25.
    push(32'd25, 2'b00, 1'b0);
    do_start(16'd3, 1'b0);
    beat(16'd10);
    tick();
    tick();
    beat(16'd20);
    tick();
    chk("t5_gap_not_done", {31'd0, bus.out_valid}, 32'd0);
    beat(-16'sd5);
    wait_done();
    tick();

    // A beat presented with start is dropped and flagged.
    push(32'd9, 2'b00, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_y     = 16'd77;
    do_start(16'd1, 1'b0);
    bus.in_valid = 1'b0;
    beat(16'd9);
    wait_done();
    tick();

    // Reset mid-run discards the partial sum immediately.
    do_start(16'd4, 1'b0);
    beat(16'd3);
    beat(16'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_data", bus.out_data, 32'd0);
    chk("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("t6_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t6_rst_drop", {31'd0, bus.err_drop}, 32'd0);
    rst = 1'b0;
    tick();
    push(32'd9, 2'b00, 1'b0);
    do_start(16'd1, 1'b0);
    beat(16'd9);
    wait_done();
    tick();
    tick();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psmac_accumulator.md
# psmac_accumulator

Downstream accumulation stage for the precision-scalable MAC unit. It takes the registered 16-bit signed partial result `y` from the MAC each cycle and accumulates a programmed number of products into a dot-product sum. It has two modes: a single wide accumulator, or two independent lanes fed from packed 8-bit halves. The finished sum is presented on a valid/ready output port.

## Interface
- `ACC_W`, default 32: total accumulator width in bits. Must be even and ≥ 32. Each split-mode lane is `ACC_W/2` bits wide.
- `LEN_W`, default 16: width of the product-count configuration.

- `clk`: in, 1. Rising-edge clock, shared with the MAC.
- `rst`: in, 1. Asynchronous, active-high reset.
- `start`: in, 1. Pulse that begins a new accumulation. Honoured only in IDLE.
- `cfg_len`: in, `LEN_W`. Number of products to accumulate. A value of 0 is treated as 1.
- `cfg_split`: in, 1. 0 = one signed accumulator fed by `in_y`. 1 = two lanes fed by `in_y[15:8]` and `in_y[7:0]`, each a signed 8-bit value.
- `in_valid`: in, 1. Qualifies `in_y` in the same cycle. Driven alongside the MAC output register.
- `in_y`: in, 16. Signed MAC result.
- `in_ready`: out, 1. High only in ACC.
- `out_valid`: out, 1. Result available.
- `out_ready`: in, 1. Consumer accepts the result.
- `out_data`: out, `ACC_W`.
  - Non-split: the full accumulator.
  - Split: `{lane_hi, lane_lo}`.
- `out_sat`: out, 2. Sticky saturation flags `{hi, lo}`. In non-split mode only bit 0 is used.
- `err_drop`: out, 1. Sticky flag: `in_valid` was seen while `in_ready`=0. Cleared by `start`.
- `busy`: out, 1. High in ACC or DONE.

## Operation
- **States:** IDLE, ACC, DONE. Encoded in 2 bits; the unused code returns to IDLE.
- **IDLE, on `start`:**
  - Latch `cfg_len` (0→1) and `cfg_split`.
  - Clear the accumulators, `out_sat`, `err_drop` and the beat counter.
  - Next state is ACC.
- **ACC, on `in_valid`:**
  - Add the sign-extended input to the accumulator(s) and increment the counter.
  - On the beat where counter = len−1, go to DONE.
- **DONE:**
  - `out_valid`=1. `out_data` and `out_sat` are held stable.
  - When `out_valid && out_ready`, go to IDLE.
- **Arithmetic:**
  - Two's-complement, saturating.
  - Non-split: `acc + sext(in_y)`, clamped to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Split: each lane computes `lane + sext(byte)`, clamped to the `ACC_W/2`-bit signed range, independently.
  - The saturation flag for a lane is set on any clamping event and stays set until the next `start`.
- **Dropped beats:** `in_valid` while in IDLE or DONE is not accumulated and sets `err_drop`. The sole exception is the cycle in which `start` is accepted: an `in_valid` in that same cycle is also dropped and also flagged.
- **`start` while busy:** ignored; it has no effect on state or flags.
- **`start` together with `out_ready` in DONE:** `start` is ignored. The handshake completes and the state moves to IDLE.

## Timing
- **Reset values:** state=IDLE, `in_ready`=0, `out_valid`=0, `out_data`=0, `out_sat`=0, `err_drop`=0, `busy`=0. Reset takes effect immediately and asynchronously, aborting any accumulation in progress; a partial result is discarded.
- **Latency:** `out_valid` rises in the cycle after the final accepted beat.
- **Minimum transaction length:** `start`, then N cycles with `in_valid`, then 1 cycle in DONE. That is N+2 cycles from `start` to the first possible handshake.
- **Register outputs:** `in_ready`, `out_valid` and `busy` are decoded directly from registered state. No combinational path exists from `out_ready` to `out_data`.
- **Throughput:** one input beat per cycle in ACC. Gaps in `in_valid` are allowed and do not advance the counter.
- **Output hold:** `out_data` holds its value after the handshake until the next `start` clears it.

## Structure
- **Package `psmac_pkg`:**
  - The state enum `acc_state_t` (IDLE/ACC/DONE).
  - The MAC result width constant `PSMAC_Y_W`=16.
  - The split byte width constant `PSMAC_LANE_IN_W`=8.
- **Sub-module `sat_add`:**
  - Parameterised by width W.
  - Signed saturating adder with an overflow flag.
  - Instantiated three times: the full-width accumulator, and one per split lane.
- **Top level:** FSM, beat counter, configuration registers, and the output mux that selects between the full accumulator and `{hi, lo}`.

## Test plan
- **Basic non-split:** `cfg_len`=4, `cfg_split`=0, inputs 100, −50, 7, −1, `out_ready`=1 → `out_data`=56, `out_sat`=0, `out_valid` exactly 1 cycle after the 4th beat.
- **Split lanes:** `cfg_len`=2, `cfg_split`=1, `in_y`=16'h05FD then 16'hFE03 → lane_hi=3, lane_lo=0, `out_data`=32'h0003_0000.
- **Saturation:** `ACC_W`=32, `cfg_split`=1, `cfg_len`=300, `in_y`=16'h7F7F every cycle → lanes reach 38100, so lane_hi=lane_lo=32767 and `out_sat`=2'b11. The sticky flags survive until the next `start`.
- **Backpressure and drops:**
  - Hold `out_ready`=0 for 5 cycles in DONE → `out_data` stays stable.
  - Pulse `in_valid` during DONE → `err_drop`=1 and the sum is unchanged.
  - Pulse `start` during DONE → ignored.
- **Gaps and len=0:** `cfg_len`=0 with one beat of −32768 → `out_data`=−32768 after one beat. With `cfg_len`=3 and idle gaps between beats → sum is correct and the count ignores the gaps.
- **Reset mid-run:** assert `rst` after 2 of 4 beats → all outputs 0 at once. A fresh `start` with len 1 and input 9 → `out_data`=9.
